// File: rtl/reduce_combine_if.sv
// rtl/reduce_combine_if.sv - flit input and result output handshake bundle for reduce_combine
interface reduce_combine_if #(
  parameter int FlitWidth     = 73,
  parameter int ChildrenWidth = 3
);
  logic [FlitWidth+ChildrenWidth-1:0] flit_in;
  logic                               in_ready;
  logic [FlitWidth-1:0]               packet_out;
  logic                               out_valid;
  logic                               out_ready;

  modport master (
    output flit_in,
    input  in_ready,
    input  packet_out,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  flit_in,
    output in_ready,
    output packet_out,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/reduce_combine.sv
// rtl/reduce_combine.sv - in-network reduction: combines flits sharing {contextId,tag} until all children arrive
module reduce_combine #(
  parameter int         FlitWidth     = 73,
  parameter int         ChildrenWidth = 3,
  parameter int         TableSize     = 4,
  parameter logic [2:0] rank_x        = 3'b0,
  parameter logic [2:0] rank_y        = 3'b0,
  parameter logic [2:0] rank_z        = 3'b0
) (
  input logic            clk,
  input logic            rst,
  reduce_combine_if.slave bus
);

  localparam int IdxW = (TableSize > 1) ? $clog2(TableSize) : 1;

  // input field decode
  logic [ChildrenWidth-1:0] in_children;
  logic                     in_valid;
  logic [8:0]               in_dst;
  logic [15:0]              in_key;
  logic [1:0]               in_alg;
  logic [3:0]               in_op;
  logic [31:0]              in_payload;
  logic [8:0]               unused_src;

  assign in_children = bus.flit_in[FlitWidth +: ChildrenWidth];
  assign in_valid    = bus.flit_in[72];
  assign in_dst      = bus.flit_in[71:63];
  assign unused_src  = bus.flit_in[62:54];
  assign in_key      = bus.flit_in[53:38];
  assign in_alg      = bus.flit_in[37:36];
  assign in_op       = bus.flit_in[35:32];
  assign in_payload  = bus.flit_in[31:0];

  logic        busy_q [TableSize];
  logic [15:0] key_q  [TableSize];
  logic [3:0]  op_q   [TableSize];
  logic [8:0]  dst_q  [TableSize];
  logic [1:0]  alg_q  [TableSize];
  logic [31:0] acc_q  [TableSize];
  logic [3:0]  rem_q  [TableSize];

  logic                 out_valid_q;
  logic [FlitWidth-1:0] packet_q;

  function automatic logic [31:0] combine(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd1:    combine = (a > b) ? a : b;
      4'd2:    combine = (a < b) ? a : b;
      4'd3:    combine = a & b;
      4'd4:    combine = a | b;
      4'd5:    combine = a ^ b;
      default: combine = a + b;
    endcase
  endfunction

  logic            match_hit;
  logic [IdxW-1:0] match_idx;
  logic            free_hit;
  logic [IdxW-1:0] free_idx;

  // descending scan leaves the lowest free index in free_idx
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = TableSize - 1; i >= 0; i--) begin
      if (busy_q[i] && (key_q[i] == in_key)) begin
        match_hit = 1'b1;
        match_idx = IdxW'(i);
      end
      if (!busy_q[i]) begin
        free_hit = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  logic stall;
  logic table_block;
  logic ready;
  logic accept;

  assign stall       = out_valid_q && !bus.out_ready;
  assign table_block = !match_hit && !free_hit && (in_children != '0);
  assign ready       = rst && !stall && !table_block;
  assign accept      = in_valid && ready;

  logic [31:0]          acc_new;
  logic [3:0]           rem_new;
  logic                 complete;
  logic [3:0]           res_op;
  logic [8:0]           res_dst;
  logic [1:0]           res_alg;
  logic [FlitWidth-1:0] result;

  always_comb begin
    acc_new = in_payload;
    rem_new = 4'(in_children);
    res_op  = in_op;
    res_dst = in_dst;
    res_alg = in_alg;
    if (match_hit) begin
      acc_new = combine(op_q[match_idx], acc_q[match_idx], in_payload);
      rem_new = rem_q[match_idx] - 4'd1;
      res_op  = op_q[match_idx];
      res_dst = dst_q[match_idx];
      res_alg = alg_q[match_idx];
    end
    complete = accept && (rem_new == 4'd0);
    result   = {1'b1, res_dst, rank_z, rank_y, rank_x, in_key, res_alg, res_op, acc_new};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TableSize; i++) begin
        busy_q[i] <= 1'b0;
        key_q[i]  <= '0;
        op_q[i]   <= '0;
        dst_q[i]  <= '0;
        alg_q[i]  <= '0;
        acc_q[i]  <= '0;
        rem_q[i]  <= '0;
      end
    end else if (accept) begin
      if (complete) begin
        if (match_hit) begin
          busy_q[match_idx] <= 1'b0;
        end
      end else if (match_hit) begin
        acc_q[match_idx] <= acc_new;
        rem_q[match_idx] <= rem_new;
      end else begin
        busy_q[free_idx] <= 1'b1;
        key_q[free_idx]  <= in_key;
        op_q[free_idx]   <= in_op;
        dst_q[free_idx]  <= in_dst;
        alg_q[free_idx]  <= in_alg;
        acc_q[free_idx]  <= acc_new;
        rem_q[free_idx]  <= rem_new;
      end
    end
  end

  // a load in the same cycle as a drain keeps out_valid high with no bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      packet_q    <= '0;
    end else if (complete) begin
      out_valid_q <= 1'b1;
      packet_q    <= result;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.packet_out = packet_q;

endmodule

// File: tb/tb_reduce_combine.sv
// tb/tb_reduce_combine.sv - scoreboard bench for reduce_combine with directed vectors
module tb_reduce_combine;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  reduce_combine_if #(.FlitWidth(73), .ChildrenWidth(3)) bus ();

  reduce_combine #(
    .FlitWidth(73), .ChildrenWidth(3), .TableSize(4),
    .rank_x(3'd1), .rank_y(3'd2), .rank_z(3'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  int n_push   = 0;
  logic [72:0] exp_q [$];

  function automatic logic [75:0] mk_in(input logic [2:0] ch, input logic [7:0] ctx,
                                        input logic [7:0] tag, input logic [1:0] alg,
                                        input logic [3:0] op, input logic [31:0] pl,
                                        input logic [8:0] dst);
    return {ch, 1'b1, dst, 9'h1AB, ctx, tag, alg, op, pl};
  endfunction

  function automatic logic [72:0] mk_out(input logic [7:0] ctx, input logic [7:0] tag,
                                         input logic [1:0] alg, input logic [3:0] op,
                                         input logic [31:0] pl, input logic [8:0] dst);
    return {1'b1, dst, 9'b011_010_001, ctx, tag, alg, op, pl};
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s got %b required %b", name, act, req);
  endtask

  task automatic check_pkt(input string name, input logic [72:0] act, input logic [72:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s got %h required %h", name, act, req);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s got %0d required %0d", name, act, req);
  endtask

  task automatic expect_out(input logic [72:0] p);
    exp_q.push_back(p);
    n_push++;
  endtask

  // present one flit for one cycle, requiring it to be accepted
  task automatic issue(input logic [75:0] f);
    bus.flit_in = f;
    @(negedge clk);
    check_bit("in_ready_accept", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.flit_in = '0;
  endtask

  // scoreboard monitor: every transfer must match the head of the queue
  initial begin
    logic [72:0] e;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output got %h required none", bus.packet_out);
        end else begin
          e = exp_q.pop_front();
          check_pkt("output", bus.packet_out, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flit_in   = mk_in(3'd0, 8'h01, 8'h01, 2'd0, 4'd0, 32'd1, 9'd0);
    bus.out_ready = 1'b1;
    #12;
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_pkt("rst_packet_out", bus.packet_out, 73'd0);
    check_bit("rst_in_ready", bus.in_ready, 1'b0);
    bus.flit_in = '0;
    @(posedge clk); #1;
    rst = 1'b1;

    // leaf: completes immediately, one-cycle latency
    expect_out(mk_out(8'h05, 8'h06, 2'd0, 4'd0, 32'd5, 9'h055));
    issue(mk_in(3'd0, 8'h05, 8'h06, 2'd0, 4'd0, 32'd5, 9'h055));
    @(negedge clk);
    check_bit("leaf_latency", bus.out_valid, 1'b1);
    @(posedge clk); #1;

    // sum of four, stored op/dst/alg win over the last input's
    issue(mk_in(3'd3, 8'h01, 8'h02, 2'd1, 4'd0, 32'd10, 9'h101));
    issue(mk_in(3'd3, 8'h01, 8'h02, 2'd1, 4'd0, 32'd20, 9'h101));
    issue(mk_in(3'd3, 8'h01, 8'h02, 2'd1, 4'd0, 32'd30, 9'h101));
    check_bit("sum_no_early_out", bus.out_valid, 1'b0);
    expect_out(mk_out(8'h01, 8'h02, 2'd1, 4'd0, 32'd100, 9'h101));
    issue(mk_in(3'd3, 8'h01, 8'h02, 2'd3, 4'd1, 32'd40, 9'h1FF));
    @(posedge clk); #1;

    // interleaved keys: A max, B min
    issue(mk_in(3'd1, 8'h03, 8'h01, 2'd0, 4'd1, 32'd7, 9'h00A));
    issue(mk_in(3'd1, 8'h03, 8'h02, 2'd0, 4'd2, 32'd9, 9'h00B));
    expect_out(mk_out(8'h03, 8'h01, 2'd0, 4'd1, 32'd7, 9'h00A));
    issue(mk_in(3'd1, 8'h03, 8'h01, 2'd0, 4'd1, 32'd3, 9'h00A));
    expect_out(mk_out(8'h03, 8'h02, 2'd0, 4'd2, 32'd4, 9'h00B));
    issue(mk_in(3'd1, 8'h03, 8'h02, 2'd0, 4'd2, 32'd4, 9'h00B));
    @(posedge clk); #1;

    // full table: open four OR keys
    issue(mk_in(3'd1, 8'h10, 8'h00, 2'd2, 4'd4, 32'h1, 9'h010));
    issue(mk_in(3'd1, 8'h11, 8'h00, 2'd2, 4'd4, 32'h2, 9'h011));
    issue(mk_in(3'd1, 8'h12, 8'h00, 2'd2, 4'd4, 32'h4, 9'h012));
    issue(mk_in(3'd1, 8'h13, 8'h00, 2'd2, 4'd4, 32'h8, 9'h013));
    bus.flit_in = mk_in(3'd2, 8'h14, 8'h00, 2'd0, 4'd0, 32'h99, 9'h014);
    @(negedge clk);
    check_bit("full_new_key_blocked", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    bus.flit_in = '0;
    expect_out(mk_out(8'h15, 8'h00, 2'd0, 4'd5, 32'h77, 9'h015));
    issue(mk_in(3'd0, 8'h15, 8'h00, 2'd0, 4'd5, 32'h77, 9'h015));
    expect_out(mk_out(8'h11, 8'h00, 2'd2, 4'd4, 32'h12, 9'h011));
    issue(mk_in(3'd1, 8'h11, 8'h00, 2'd2, 4'd4, 32'h10, 9'h011));
    expect_out(mk_out(8'h10, 8'h00, 2'd2, 4'd4, 32'h21, 9'h010));
    issue(mk_in(3'd1, 8'h10, 8'h00, 2'd2, 4'd4, 32'h20, 9'h010));
    expect_out(mk_out(8'h12, 8'h00, 2'd2, 4'd4, 32'h44, 9'h012));
    issue(mk_in(3'd1, 8'h12, 8'h00, 2'd2, 4'd4, 32'h40, 9'h012));
    expect_out(mk_out(8'h13, 8'h00, 2'd2, 4'd4, 32'h88, 9'h013));
    issue(mk_in(3'd1, 8'h13, 8'h00, 2'd2, 4'd4, 32'h80, 9'h013));
    @(posedge clk); #1;

    // backpressure with simultaneous drain and load
    issue(mk_in(3'd1, 8'h21, 8'h00, 2'd0, 4'd0, 32'd5, 9'h021));
    bus.out_ready = 1'b0;
    expect_out(mk_out(8'h20, 8'h00, 2'd0, 4'd3, 32'hF0F0, 9'h020));
    issue(mk_in(3'd0, 8'h20, 8'h00, 2'd0, 4'd3, 32'hF0F0, 9'h020));
    bus.flit_in = mk_in(3'd1, 8'h21, 8'h00, 2'd0, 4'd0, 32'd6, 9'h021);
    repeat (2) begin
      @(negedge clk);
      check_bit("stall_in_ready", bus.in_ready, 1'b0);
      check_pkt("stall_packet_stable", bus.packet_out,
                mk_out(8'h20, 8'h00, 2'd0, 4'd3, 32'hF0F0, 9'h020));
    end
    expect_out(mk_out(8'h21, 8'h00, 2'd0, 4'd0, 32'd11, 9'h021));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_bit("release_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.flit_in = '0;
    @(negedge clk);
    check_bit("no_bubble", bus.out_valid, 1'b1);
    @(posedge clk); #1;

    // 32-bit wraparound
    issue(mk_in(3'd1, 8'h30, 8'h00, 2'd0, 4'd0, 32'hFFFF_FFFF, 9'h030));
    expect_out(mk_out(8'h30, 8'h00, 2'd0, 4'd0, 32'd1, 9'h030));
    issue(mk_in(3'd1, 8'h30, 8'h00, 2'd0, 4'd0, 32'd2, 9'h030));
    @(posedge clk); #1;

    // reset mid-reduction discards the partial entry
    issue(mk_in(3'd2, 8'h31, 8'h00, 2'd0, 4'd0, 32'd7, 9'h031));
    @(posedge clk); #2;
    rst = 1'b0;
    #2;
    check_bit("midrst_out_valid", bus.out_valid, 1'b0);
    check_bit("midrst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(negedge clk);
    check_bit("post_rst_out_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    issue(mk_in(3'd1, 8'h31, 8'h00, 2'd0, 4'd0, 32'd9, 9'h031));
    expect_out(mk_out(8'h31, 8'h00, 2'd0, 4'd0, 32'd10, 9'h031));
    issue(mk_in(3'd1, 8'h31, 8'h00, 2'd0, 4'd0, 32'd1, 9'h031));

    repeat (4) @(posedge clk);
    #1;
    check_int("outputs_seen", n_out, n_push);
    check_int("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
